// File: rtl/iq_enq_alloc.sv
// ---------------------------------------------------------------------------
// iq_enq_alloc
// Enqueue-side allocator for an issue queue. Accepts one instruction per
// cycle from dispatch over a valid/ready handshake, selects a free entry,
// and owns the per-entry occupancy vector (set on enqueue, cleared on
// dequeue or flush).
//
// Optional feature macro: IQ_ENQ_ALLOC_RR_EN
//   defined   : next-fit selection starting at a rotating pointer
//   undefined : fixed lowest-index-free selection, no pointer register
//
// Ports:
//   clock              in   rising-edge clock
//   reset_n            in   asynchronous active-low reset
//   enq_valid          in   dispatch presents an instruction
//   enq_ready          out  allocator can accept this cycle
//   enq_fire           out  enq_valid & enq_ready
//   iq_entries_wren_oh out  one-hot entry written this cycle (0 when no fire)
//   enq_ptr            out  binary index of allocated entry (0 when no fire)
//   deq_fire           in   an entry issued this cycle
//   deq_ptr            in   index of the issued entry
//   flush_valid        in   flush this cycle
//   flush_mask         in   entries to kill
//   iq_entries_valid   out  registered occupancy vector
//   free_count         out  registered number of free entries
//   iq_full            out  free_count == 0
// ---------------------------------------------------------------------------
module iq_enq_alloc #(
    parameter int DEPTH = 8,
    parameter int LOG   = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic             enq_fire,
    output logic [DEPTH-1:0] iq_entries_wren_oh,
    output logic [LOG-1:0]   enq_ptr,
    input  logic             deq_fire,
    input  logic [LOG-1:0]   deq_ptr,
    input  logic             flush_valid,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [DEPTH-1:0] iq_entries_valid,
    output logic [LOG:0]     free_count,
    output logic             iq_full
);

    logic [DEPTH-1:0] r_valid;
    logic [LOG:0]     r_free_count;

    logic [LOG-1:0]   w_sel;
    logic [DEPTH-1:0] w_wren;
    logic [DEPTH-1:0] w_deq_clr;
    logic [DEPTH-1:0] w_flush_clr;
    logic [DEPTH-1:0] w_freed;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [LOG:0]     w_free_nxt;
    logic             w_fire;

    function automatic logic [LOG:0] f_popcount(input logic [DEPTH-1:0] v);
        logic [LOG:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{LOG{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Readiness uses only current registered state; a same-cycle dequeue
    // is not bypassed, so a full queue stays not-ready.
    assign iq_full   = (r_free_count == '0);
    assign enq_ready = !iq_full && !flush_valid;
    assign w_fire    = enq_valid && enq_ready;
    assign enq_fire  = w_fire;

`ifdef IQ_ENQ_ALLOC_RR_EN
    logic [LOG-1:0] r_rr_ptr;
    logic [LOG-1:0] w_idx;

    // Scan offsets from the far end down to 0 so the last hit is the
    // nearest free entry at or after the pointer; LOG-bit add wraps.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = r_rr_ptr + LOG'(k);
            if (!r_valid[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= w_sel + LOG'(1);
        end
    end
`else
    // Descending scan: the last free entry seen is the lowest index.
    always_comb begin
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_sel = LOG'(i);
            end
        end
    end
`endif

    always_comb begin
        w_wren = '0;
        if (w_fire) begin
            w_wren[w_sel] = 1'b1;
        end
    end

    assign iq_entries_wren_oh = w_wren;
    assign enq_ptr            = w_fire ? w_sel : '0;

    // A dequeue of an already-invalid entry contributes nothing.
    always_comb begin
        w_deq_clr = '0;
        if (deq_fire) begin
            w_deq_clr[deq_ptr] = r_valid[deq_ptr];
        end
    end

    assign w_flush_clr = flush_valid ? flush_mask : '0;

    // Union of deq and flush so an entry hit by both is freed once.
    assign w_freed     = (w_deq_clr | w_flush_clr) & r_valid;
    assign w_valid_nxt = (r_valid | w_wren) & ~(w_deq_clr | w_flush_clr);
    assign w_free_nxt  = r_free_count - {{LOG{1'b0}}, w_fire} + f_popcount(w_freed);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_free_count <= (LOG+1)'(DEPTH);
        end else begin
            r_valid      <= w_valid_nxt;
            r_free_count <= w_free_nxt;
        end
    end

    assign iq_entries_valid = r_valid;
    assign free_count       = r_free_count;

`ifndef SYNTHESIS
    a_wren_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(iq_entries_wren_oh));

    a_enq_target_free: assert property (@(posedge clock) disable iff (!reset_n)
        enq_fire |-> ((iq_entries_wren_oh & r_valid) == '0));

    a_free_invariant: assert property (@(posedge clock) disable iff (!reset_n)
        (int'(r_free_count) + $countones(r_valid)) == DEPTH);

    a_no_enq_in_flush: assert property (@(posedge clock) disable iff (!reset_n)
        !(enq_fire && flush_valid));
`endif

endmodule

// File: tb/tb_iq_enq_alloc.sv
module tb_iq_enq_alloc;

    localparam int DEPTH = 8;
    localparam int LOG   = 3;

    logic             clock;
    logic             reset_n;
    logic             enq_valid;
    logic             enq_ready;
    logic             enq_fire;
    logic [DEPTH-1:0] iq_entries_wren_oh;
    logic [LOG-1:0]   enq_ptr;
    logic             deq_fire;
    logic [LOG-1:0]   deq_ptr;
    logic             flush_valid;
    logic [DEPTH-1:0] flush_mask;
    logic [DEPTH-1:0] iq_entries_valid;
    logic [LOG:0]     free_count;
    logic             iq_full;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy set and next-fit start position.
    logic [DEPTH-1:0] mv;
    int               m_ptr;

    iq_enq_alloc #(.DEPTH(DEPTH), .LOG(LOG)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .enq_valid          (enq_valid),
        .enq_ready          (enq_ready),
        .enq_fire           (enq_fire),
        .iq_entries_wren_oh (iq_entries_wren_oh),
        .enq_ptr            (enq_ptr),
        .deq_fire           (deq_fire),
        .deq_ptr            (deq_ptr),
        .flush_valid        (flush_valid),
        .flush_mask         (flush_mask),
        .iq_entries_valid   (iq_entries_valid),
        .free_count         (free_count),
        .iq_full            (iq_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int m_pick();
        int start;
`ifdef IQ_ENQ_ALLOC_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (!mv[(start + k) % DEPTH]) return (start + k) % DEPTH;
        end
        return -1;
    endfunction

    function automatic bit m_ready();
        return ($countones(mv) < DEPTH) && !flush_valid;
    endfunction

    task automatic drive(input logic ev, input logic df, input int dp,
                         input logic fv, input logic [DEPTH-1:0] fm);
        @(negedge clock);
        enq_valid   = ev;
        deq_fire    = df;
        deq_ptr     = dp[LOG-1:0];
        flush_valid = fv;
        flush_mask  = fm;
        #1;
    endtask

    task automatic tick();
        bit               fire;
        int               p;
        logic [DEPTH-1:0] nv;
        fire = enq_valid && m_ready();
        p    = m_pick();
        nv   = mv;
        if (fire) nv[p] = 1'b1;
        if (deq_fire && mv[deq_ptr]) nv[deq_ptr] = 1'b0;
        if (flush_valid) nv = nv & ~flush_mask;
        if (fire) m_ptr = (p + 1) % DEPTH;
        @(posedge clock);
        mv = nv;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; enq_valid = 0; deq_fire = 0; deq_ptr = '0;
        flush_valid = 0; flush_mask = '0;
        mv = '0; m_ptr = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0; enq_valid = 0; deq_fire = 0; deq_ptr = '0;
        flush_valid = 0; flush_mask = '0;
        mv = '0; m_ptr = 0;
        #1;
        checks++; if (iq_entries_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want 00", iq_entries_valid); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free got %0d want 8", free_count); end
        checks++; if (iq_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", iq_full); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", enq_ready); end
    endtask

    task automatic test_fill();
        logic [DEPTH-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0, '0);
            exp_oh = 8'h01 << i;
            checks++; if (enq_fire !== 1'b1) begin errors++; $display("FAIL fill_fire[%0d] got %b want 1", i, enq_fire); end
            checks++; if (enq_ptr !== i[LOG-1:0]) begin errors++; $display("FAIL fill_ptr[%0d] got %0d want %0d", i, enq_ptr, i); end
            checks++; if (iq_entries_wren_oh !== exp_oh) begin errors++; $display("FAIL fill_oh[%0d] got %h want %h", i, iq_entries_wren_oh, exp_oh); end
            tick();
        end
        drive(1, 0, 0, 0, '0);
        checks++; if (iq_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", iq_full); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", enq_ready); end
        checks++; if (free_count !== 4'd0) begin errors++; $display("FAIL fill_free got %0d want 0", free_count); end
    endtask

    task automatic test_full_deq();
        // Continues from a full queue left by test_fill.
        drive(1, 1, 3, 0, '0);
        checks++; if (enq_fire !== 1'b0) begin errors++; $display("FAIL fulldeq_fire got %b want 0", enq_fire); end
        checks++; if (iq_entries_wren_oh !== 8'h00) begin errors++; $display("FAIL fulldeq_oh got %h want 00", iq_entries_wren_oh); end
        tick();
        drive(1, 0, 0, 0, '0);
        checks++; if (enq_ptr !== 3'd3) begin errors++; $display("FAIL fulldeq_ptr got %0d want 3", enq_ptr); end
        checks++; if (iq_entries_wren_oh !== 8'h08) begin errors++; $display("FAIL fulldeq_oh2 got %h want 08", iq_entries_wren_oh); end
        tick();
        drive(0, 0, 0, 0, '0);
        checks++; if (iq_full !== 1'b1) begin errors++; $display("FAIL fulldeq_full got %b want 1", iq_full); end
    endtask

    task automatic test_enq_deq_same();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, '0);
            tick();
        end
        drive(1, 1, 2, 0, '0);
        checks++; if (enq_ptr !== 3'd6) begin errors++; $display("FAIL samecyc_ptr got %0d want 6", enq_ptr); end
        tick();
        checks++; if (iq_entries_valid !== 8'h7B) begin errors++; $display("FAIL samecyc_valid got %h want 7b", iq_entries_valid); end
        checks++; if (free_count !== 4'd2) begin errors++; $display("FAIL samecyc_free got %0d want 2", free_count); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0, '0);
            tick();
        end
        drive(1, 0, 0, 1, 8'hF0);
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", enq_ready); end
        checks++; if (enq_fire !== 1'b0) begin errors++; $display("FAIL flush_fire got %b want 0", enq_fire); end
        tick();
        checks++; if (iq_entries_valid !== 8'h0F) begin errors++; $display("FAIL flush_valid got %h want 0f", iq_entries_valid); end
        checks++; if (free_count !== 4'd4) begin errors++; $display("FAIL flush_free got %0d want 4", free_count); end
        drive(1, 0, 0, 0, '0);
        checks++; if (enq_ptr !== 3'd4) begin errors++; $display("FAIL flush_ptr got %0d want 4", enq_ptr); end
        tick();
    endtask

    task automatic test_deq_invalid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, '0);
            tick();
        end
        drive(0, 1, 5, 0, '0);
        tick();
        checks++; if (iq_entries_valid !== 8'h03) begin errors++; $display("FAIL deqinv_valid got %h want 03", iq_entries_valid); end
        checks++; if (free_count !== 4'd6) begin errors++; $display("FAIL deqinv_free got %0d want 6", free_count); end
        drive(0, 1, 1, 1, 8'h02);
        tick();
        checks++; if (free_count !== 4'd7) begin errors++; $display("FAIL deqflush_free got %0d want 7", free_count); end
        checks++; if (iq_entries_valid !== 8'h01) begin errors++; $display("FAIL deqflush_valid got %h want 01", iq_entries_valid); end
        // Empty queue: dequeue changes nothing.
        drive(0, 1, 0, 1, 8'h01);
        tick();
        drive(0, 1, 0, 0, '0);
        tick();
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL deqempty_free got %0d want 8", free_count); end
    endtask

    task automatic test_selection_order();
        int exp_seq [6];
`ifdef IQ_ENQ_ALLOC_RR_EN
        exp_seq = '{3, 4, 5, 6, 7, 0};
`else
        exp_seq = '{0, 3, 4, 5, 6, 7};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, '0);
            tick();
        end
        drive(0, 1, 0, 0, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, '0);
            checks++; if (enq_ptr !== exp_seq[i][LOG-1:0]) begin errors++; $display("FAIL order_ptr[%0d] got %0d want %0d", i, enq_ptr, exp_seq[i]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, '0);
            tick();
        end
        drive(0, 0, 0, 0, '0);
        reset_n = 1'b0;
        mv = '0; m_ptr = 0;
        #1;
        checks++; if (iq_entries_valid !== 8'h00) begin errors++; $display("FAIL midrst_valid got %h want 00", iq_entries_valid); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL midrst_free got %0d want 8", free_count); end
        @(negedge clock);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, '0);
        checks++; if (enq_ptr !== 3'd0) begin errors++; $display("FAIL midrst_ptr got %0d want 0", enq_ptr); end
        tick();
    endtask

    task automatic test_random();
        int               p;
        bit               exp_ready;
        bit               exp_fire;
        logic [LOG-1:0]   exp_ptr;
        logic [DEPTH-1:0] exp_oh;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, 19) == 0,
                  DEPTH'($urandom));
            p         = m_pick();
            exp_ready = m_ready();
            exp_fire  = enq_valid && exp_ready;
            exp_ptr   = exp_fire ? p[LOG-1:0] : '0;
            exp_oh    = exp_fire ? (8'h01 << p) : 8'h00;
            checks++; if (enq_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, enq_ready, exp_ready); end
            checks++; if (enq_fire !== exp_fire) begin errors++; $display("FAIL rnd_fire[%0d] got %b want %b", n, enq_fire, exp_fire); end
            checks++; if (enq_ptr !== exp_ptr) begin errors++; $display("FAIL rnd_ptr[%0d] got %0d want %0d", n, enq_ptr, exp_ptr); end
            checks++; if (iq_entries_wren_oh !== exp_oh) begin errors++; $display("FAIL rnd_oh[%0d] got %h want %h", n, iq_entries_wren_oh, exp_oh); end
            tick();
            checks++; if (iq_entries_valid !== mv) begin errors++; $display("FAIL rnd_valid[%0d] got %h want %h", n, iq_entries_valid, mv); end
            checks++; if (int'(free_count) != DEPTH - $countones(mv)) begin errors++; $display("FAIL rnd_free[%0d] got %0d want %0d", n, free_count, DEPTH - $countones(mv)); end
            checks++; if (iq_full !== (mv == '1)) begin errors++; $display("FAIL rnd_full[%0d] got %b want %b", n, iq_full, (mv == '1)); end
        end
    endtask

    initial begin
        reset_n = 1'b0; enq_valid = 0; deq_fire = 0; deq_ptr = '0;
        flush_valid = 0; flush_mask = '0; mv = '0; m_ptr = 0;
        test_reset();
        test_fill();
        test_full_deq();
        test_enq_deq_same();
        test_flush();
        test_deq_invalid();
        test_selection_order();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
